// File: rtl/core_pkg.sv
// Shared core definitions: forwarding select codes, register index width and shadow-pipeline records.
package core_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Execute-stage shadow entry
  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             regw;
    logic             load;
    logic             md;
  } shadow_t;

  // Memory/writeback shadow entry: only the destination matters past E
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regw;
  } wb_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-stage hazard inputs and pipeline stall/flush/forward controls.
interface hazard_ctrl_if;
  import core_pkg::*;

  logic [REG_W-1:0] Rs1D;
  logic [REG_W-1:0] Rs2D;
  logic [REG_W-1:0] RdD;
  logic             RegWriteD;
  logic             LoadD;
  logic             MulDivD;
  logic             PCSrcE;
  logic [1:0]       Forward_AE;
  logic [1:0]       Forward_BE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             FlushD;
  logic             FlushE;

  // Pipeline datapath side
  modport master (
    output Rs1D, Rs2D, RdD, RegWriteD, LoadD, MulDivD, PCSrcE,
    input  Forward_AE, Forward_BE, StallF, StallD, StallE, FlushD, FlushE
  );

  // Hazard controller side
  modport slave (
    input  Rs1D, Rs2D, RdD, RegWriteD, LoadD, MulDivD, PCSrcE,
    output Forward_AE, Forward_BE, StallF, StallD, StallE, FlushD, FlushE
  );

endinterface

// File: rtl/fwd_sel.sv
// Per-operand forward decode: nearest in-flight writer wins, x0 never forwarded.
module fwd_sel
  import core_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] rd_m,
  input  logic             regw_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             regw_w,
  output logic [1:0]       sel
);

  // M-stage result is younger than W-stage, so it is checked first
  always_comb begin
    sel = FWD_REG;
    if (src != '0) begin
      if (regw_m && (rd_m == src)) begin
        sel = FWD_MEM;
      end else if (regw_w && (rd_w == src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Execute-stage sequencing: forwarding selects, load-use bubbles, branch flushes, mul/div occupancy.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 3
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hz
);

  logic [CNT_W-1:0] cnt;
  shadow_t          e_q;
  wb_t              m_q;
  wb_t              w_q;
  shadow_t          d_in;
  logic             busy;
  logic             lw_stall;
  logic             flush_e;
  logic             redirect;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  // Hazard detection and control outputs; reset forces flushes and masks everything else
  always_comb begin
    d_in     = '{rs1: hz.Rs1D, rs2: hz.Rs2D, rd: hz.RdD,
                 regw: hz.RegWriteD, load: hz.LoadD, md: hz.MulDivD};
    busy     = rst_n && (cnt != '0);
    lw_stall = rst_n && e_q.load && (e_q.rd != '0) &&
               ((e_q.rd == hz.Rs1D) || (e_q.rd == hz.Rs2D));
    redirect = rst_n && !busy && hz.PCSrcE;
    flush_e  = !busy && (hz.PCSrcE || lw_stall);

    hz.StallE     = busy;
    hz.StallF     = busy || (lw_stall && !hz.PCSrcE);
    hz.StallD     = busy || (lw_stall && !hz.PCSrcE);
    hz.FlushD     = !rst_n || redirect;
    hz.FlushE     = !rst_n || flush_e;
    hz.Forward_AE = rst_n ? fwd_a : FWD_REG;
    hz.Forward_BE = rst_n ? fwd_b : FWD_REG;
  end

  // Shadow pipeline and mul/div busy counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      w_q <= m_q;
      if (busy) begin
        m_q <= '0;
        cnt <= cnt - CNT_W'(1);
      end else begin
        m_q <= '{rd: e_q.rd, regw: e_q.regw};
        if (flush_e) begin
          e_q <= '0;
        end else begin
          e_q <= d_in;
          cnt <= hz.MulDivD ? CNT_W'(MULDIV_LAT - 1) : '0;
        end
      end
    end
  end

  fwd_sel u_fwd_a (
    .src    (e_q.rs1),
    .rd_m   (m_q.rd),
    .regw_m (m_q.regw),
    .rd_w   (w_q.rd),
    .regw_w (w_q.regw),
    .sel    (fwd_a)
  );

  fwd_sel u_fwd_b (
    .src    (e_q.rs2),
    .rd_m   (m_q.rd),
    .regw_m (m_q.regw),
    .rd_w   (w_q.rd),
    .regw_w (w_q.regw),
    .sel    (fwd_b)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed test-plan scenarios, then randomized traffic vs an instruction-level model.
module tb_hazard_ctrl;

  localparam int unsigned LAT = 4;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       regw;
    logic       load;
    logic       md;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  int checks   = 0;
  int failures = 0;

  // Model: one instruction record per stage, plus how long E's occupant has been there
  ins_t pe, pm, pw;
  int   e_age;
  bit   exp_stall_d;

  // Outputs observed in the most recent step
  int o_sf, o_sd, o_se, o_fd, o_fe, o_fa, o_fb;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic ins_t mk(input int rs1, input int rs2, input int rd,
                              input bit regw, input bit load, input bit md);
    ins_t i;
    i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.rd = 5'(rd);
    i.regw = regw; i.load = load; i.md = md;
    return i;
  endfunction

  // Nearest older writer of x among M then W; x0 reads the register file
  function automatic int exp_fwd(input logic [4:0] x);
    if (x == 0) return 0;
    if (pm.regw && pm.rd == x) return 2;
    if (pw.regw && pw.rd == x) return 1;
    return 0;
  endfunction

  // A mul/div keeps E for LAT cycles and holds everything behind it for the first LAT-1
  function automatic bit model_busy();
    return pe.md && (e_age < int'(LAT) - 1);
  endfunction

  // Drive one cycle, compare all outputs against the model, then advance both across the edge
  task automatic step(input bit rst, input ins_t d, input bit pc);
    bit busy, lw, e_sf, e_se, e_fd, e_fe;
    int e_fa, e_fb;
    rst_n        = rst;
    hz.Rs1D      = d.rs1;
    hz.Rs2D      = d.rs2;
    hz.RdD       = d.rd;
    hz.RegWriteD = d.regw;
    hz.LoadD     = d.load;
    hz.MulDivD   = d.md;
    hz.PCSrcE    = pc;
    #1;
    busy = rst && model_busy();
    lw   = rst && pe.load && pe.rd != 0 && (pe.rd == d.rs1 || pe.rd == d.rs2);
    e_se = busy;
    e_sf = busy || (lw && !pc);
    e_fd = !rst || (!busy && pc);
    e_fe = !rst || (!busy && (pc || lw));
    e_fa = rst ? exp_fwd(pe.rs1) : 0;
    e_fb = rst ? exp_fwd(pe.rs2) : 0;
    o_sf = int'(hz.StallF);  o_sd = int'(hz.StallD);  o_se = int'(hz.StallE);
    o_fd = int'(hz.FlushD);  o_fe = int'(hz.FlushE);
    o_fa = int'(hz.Forward_AE); o_fb = int'(hz.Forward_BE);
    check_val("StallF", o_sf, int'(e_sf));
    check_val("StallD", o_sd, int'(e_sf));
    check_val("StallE", o_se, int'(e_se));
    check_val("FlushD", o_fd, int'(e_fd));
    check_val("FlushE", o_fe, int'(e_fe));
    check_val("Forward_AE", o_fa, e_fa);
    check_val("Forward_BE", o_fb, e_fb);
    exp_stall_d = e_sf;
    @(posedge clk);
    if (!rst) begin
      pe = '0; pm = '0; pw = '0; e_age = 0;
    end else begin
      pw = pm;
      if (busy) begin
        pm = '0;
        e_age++;
      end else begin
        pm = pe;
        pe = e_fe ? ins_t'('0) : d;
        e_age = 0;
      end
    end
    #1;
  endtask

  initial begin
    ins_t nop, d;
    bit   rst, pc;
    nop = '0;
    pe = '0; pm = '0; pw = '0; e_age = 0; exp_stall_d = 0;

    // Reset
    step(0, nop, 0);
    step(0, nop, 0);
    check_val("rst_flushd", o_fd, 1);
    check_val("rst_stallf", o_sf, 0);

    // ALU-ALU forwarding: add x5; sub x6,x5,x3; or x10,x5,x4
    step(1, mk(1, 2, 5, 1, 0, 0), 0);
    step(1, mk(5, 3, 6, 1, 0, 0), 0);
    step(1, mk(5, 4, 10, 1, 0, 0), 0);
    check_val("dir_fwd_a_mem", o_fa, 2);
    step(1, nop, 0);
    check_val("dir_fwd_a_wb", o_fa, 1);

    // Load-use: lw x7; add x11,x1,x7
    step(1, mk(1, 0, 7, 1, 1, 0), 0);
    step(1, mk(1, 7, 11, 1, 0, 0), 0);
    check_val("dir_lu_stalld", o_sd, 1);
    check_val("dir_lu_flushe", o_fe, 1);
    step(1, mk(1, 7, 11, 1, 0, 0), 0);
    check_val("dir_lu_once", o_sd, 0);
    step(1, nop, 0);
    check_val("dir_lu_fwd_b", o_fb, 1);

    // x0 is never forwarded
    step(1, mk(1, 2, 0, 1, 0, 0), 0);
    step(1, mk(0, 0, 12, 1, 0, 0), 0);
    step(1, nop, 0);
    check_val("dir_x0_fwd_a", o_fa, 0);

    // Mul/div occupancy then dependent add
    step(1, mk(1, 2, 9, 1, 0, 1), 0);
    for (int i = 0; i < 3; i++) begin
      step(1, mk(9, 1, 13, 1, 0, 0), 0);
      check_val("dir_md_stalle", o_se, 1);
    end
    step(1, mk(9, 1, 13, 1, 0, 0), 0);
    check_val("dir_md_release", o_sf, 0);
    step(1, nop, 0);
    check_val("dir_md_fwd_a", o_fa, 2);

    // Branch with simultaneous load-use: flush only
    step(1, mk(1, 0, 8, 1, 1, 0), 0);
    step(1, mk(8, 0, 14, 1, 0, 0), 1);
    check_val("dir_br_stallf", o_sf, 0);
    check_val("dir_br_flushd", o_fd, 1);
    step(1, nop, 0);
    check_val("dir_br_one_cycle", o_fd, 0);

    // Reset during the second busy cycle
    step(1, mk(1, 2, 15, 1, 0, 1), 0);
    step(1, nop, 0);
    step(0, nop, 0);
    step(1, nop, 0);
    check_val("dir_rst_busy_stalle", o_se, 0);
    check_val("dir_rst_busy_fwd", o_fa, 0);

    // Randomized traffic; D held while stalled, no branch while mul/div occupies E
    d = nop;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 79) != 0);
      if (!exp_stall_d) begin
        d.rs1  = 5'($urandom_range(0, 7));
        d.rs2  = 5'($urandom_range(0, 7));
        d.rd   = 5'($urandom_range(0, 7));
        d.load = ($urandom_range(0, 3) == 0);
        d.md   = !d.load && ($urandom_range(0, 5) == 0);
        d.regw = d.load || ($urandom_range(0, 4) != 0);
      end
      pc = !model_busy() && ($urandom_range(0, 7) == 0);
      step(rst, d, pc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
